// File: rtl/amp_seq_pkg.sv
// Shared encodings and sizing helpers for the multi-channel amplifier sequencer.
package amp_seq_pkg;

  localparam int STATE_W     = 3;
  localparam int RETRY_W     = 3;
  localparam int FORGIVE_CYC = 65536;
  localparam int FORGIVE_W   = 17;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT       = 3'd0,
    ST_EN_WAIT    = 3'd1,
    ST_CFG        = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAULT      = 3'd4,
    ST_RETRY_WAIT = 3'd5,
    ST_LOCKOUT    = 3'd6
  } state_t;

  // Timer must hold the largest programmed delay plus one spare bit.
  function automatic int timer_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/amp_timer_ld.sv
// Loadable down-counter with zero flag; load beats decrement and the count holds at zero.
module amp_timer_ld
  import amp_seq_pkg::*;
#(
  parameter int TW = 8
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          zero
);

  logic [TW-1:0] count;

  // Down-count toward zero unless a new interval is being loaded.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      count <= {TW{1'b0}};
    end else if (load) begin
      count <= load_val;
    end else if (count != {TW{1'b0}}) begin
      count <= count - {{(TW-1){1'b0}}, 1'b1};
    end
  end

  assign zero = (count == {TW{1'b0}});

endmodule

// File: rtl/amp_seq_multi.sv
// Enable/settle/config/unmute sequencer for N_CH amplifier channels on one shared enable pin,
// with per-channel fault muting, filtered fault escalation, bounded retries and lockout.
module amp_seq_multi
  import amp_seq_pkg::*;
#(
  parameter int N_CH           = 2,
  parameter int EN_WAIT_CYC    = 1000,
  parameter int CFG_TO_CYC     = 4000,
  parameter int FILT_CYC       = 16,
  parameter int RETRY_WAIT_CYC = 10000,
  parameter int MAX_RETRY      = 3
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            audio_locked_in,
  input  logic [N_CH-1:0] nerror_in,
  input  logic            cfg_done_in,
  input  logic            clear_fault_in,
  output logic            nenable_out,
  output logic [N_CH-1:0] nmute_out,
  output logic            send_config_out,
  output logic            fault_out,
  output logic [2:0]      retry_cnt_out,
  output logic [2:0]      state_out
);

  localparam int TW = timer_width(EN_WAIT_CYC, CFG_TO_CYC, FILT_CYC, RETRY_WAIT_CYC);
  localparam int FW = $clog2(FILT_CYC + 1);

  state_t               state;
  logic [RETRY_W-1:0]   retry_cnt;
  logic [FORGIVE_W-1:0] forgive_cnt;
  logic                 tmr_load;
  logic [TW-1:0]        tmr_val;
  logic                 tmr_zero;
  logic [N_CH-1:0]      trip;
  logic                 filt_trip;
  logic                 can_retry;

  assign can_retry = (retry_cnt < RETRY_W'(MAX_RETRY));

  amp_timer_ld #(.TW(TW)) u_timer (
    .clk_in   (clk_in),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Timer reloads mirror the FSM transitions that start a new interval.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = {TW{1'b0}};
    case (state)
      ST_INIT: begin
        tmr_load = 1'b1;
        tmr_val  = TW'(EN_WAIT_CYC - 1);
      end
      ST_EN_WAIT: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(CFG_TO_CYC - 1);
        end else begin
          tmr_load = 1'b0;
        end
      end
      ST_FAULT: begin
        if (can_retry) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(RETRY_WAIT_CYC - 1);
        end else begin
          tmr_load = 1'b0;
        end
      end
      default: begin
        tmr_load = 1'b0;
        tmr_val  = {TW{1'b0}};
      end
    endcase
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_filt
    logic [FW-1:0] cnt;

    // Saturating count of consecutive fault cycles, only meaningful while running.
    always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
        cnt <= {FW{1'b0}};
      end else if (state != ST_RUN || nerror_in[i]) begin
        cnt <= {FW{1'b0}};
      end else if (cnt != FW'(FILT_CYC)) begin
        cnt <= cnt + {{(FW-1){1'b0}}, 1'b1};
      end
    end

    assign trip[i] = (cnt == FW'(FILT_CYC));
  end

  assign filt_trip = |trip;

  // Main sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state           <= ST_INIT;
      nenable_out     <= 1'b1;
      nmute_out       <= {N_CH{1'b0}};
      send_config_out <= 1'b0;
      fault_out       <= 1'b0;
      retry_cnt       <= {RETRY_W{1'b0}};
      forgive_cnt     <= {FORGIVE_W{1'b0}};
    end else begin
      send_config_out <= 1'b0;
      forgive_cnt     <= {FORGIVE_W{1'b0}};
      case (state)
        ST_INIT: begin
          state       <= ST_EN_WAIT;
          nenable_out <= 1'b0;
          nmute_out   <= {N_CH{1'b0}};
          fault_out   <= 1'b0;
        end
        ST_EN_WAIT: begin
          nmute_out <= {N_CH{1'b0}};
          if (tmr_zero) begin
            state           <= ST_CFG;
            send_config_out <= 1'b1;
          end
        end
        ST_CFG: begin
          if (cfg_done_in) begin
            state     <= ST_RUN;
            nmute_out <= {N_CH{audio_locked_in}} & nerror_in;
          end else if (tmr_zero) begin
            state       <= ST_FAULT;
            nmute_out   <= {N_CH{1'b0}};
            nenable_out <= 1'b1;
            fault_out   <= 1'b1;
          end else begin
            nmute_out <= {N_CH{1'b0}};
          end
        end
        ST_RUN: begin
          if (filt_trip) begin
            state       <= ST_FAULT;
            nmute_out   <= {N_CH{1'b0}};
            nenable_out <= 1'b1;
            fault_out   <= 1'b1;
          end else begin
            nmute_out <= {N_CH{audio_locked_in}} & nerror_in;
            // A long stable run forgives earlier retries.
            if (forgive_cnt != FORGIVE_W'(FORGIVE_CYC)) begin
              forgive_cnt <= forgive_cnt + {{(FORGIVE_W-1){1'b0}}, 1'b1};
            end else begin
              forgive_cnt <= forgive_cnt;
            end
            if (forgive_cnt == FORGIVE_W'(FORGIVE_CYC - 1)) begin
              retry_cnt <= {RETRY_W{1'b0}};
            end
          end
        end
        ST_FAULT: begin
          nmute_out   <= {N_CH{1'b0}};
          nenable_out <= 1'b1;
          fault_out   <= 1'b1;
          if (can_retry) begin
            retry_cnt <= retry_cnt + {{(RETRY_W-1){1'b0}}, 1'b1};
            state     <= ST_RETRY_WAIT;
          end else begin
            state <= ST_LOCKOUT;
          end
        end
        ST_RETRY_WAIT: begin
          nmute_out   <= {N_CH{1'b0}};
          nenable_out <= 1'b1;
          if (tmr_zero) begin
            state     <= ST_INIT;
            fault_out <= 1'b0;
          end
        end
        ST_LOCKOUT: begin
          nmute_out   <= {N_CH{1'b0}};
          nenable_out <= 1'b1;
          if (clear_fault_in) begin
            state     <= ST_INIT;
            retry_cnt <= {RETRY_W{1'b0}};
            fault_out <= 1'b0;
          end
        end
        default: begin
          state       <= ST_INIT;
          nenable_out <= 1'b1;
          nmute_out   <= {N_CH{1'b0}};
          fault_out   <= 1'b0;
        end
      endcase
    end
  end

  assign retry_cnt_out = retry_cnt;
  assign state_out     = state;

endmodule

// File: tb/tb_amp_seq_multi.sv
// Scoreboard bench for amp_seq_multi with short timer parameters.
module tb_amp_seq_multi;

  localparam int N_CH  = 2;
  localparam int EN_W  = 8;
  localparam int CFG_T = 20;
  localparam int FILT  = 16;
  localparam int RW    = 12;
  localparam int MAXR  = 3;

  localparam logic [2:0] S_INIT = 3'd0, S_ENW = 3'd1, S_CFG = 3'd2, S_RUN = 3'd3,
                         S_FAULT = 3'd4, S_RWAIT = 3'd5, S_LOCK = 3'd6;

  logic            clk_in = 1'b0;
  logic            reset = 1'b0;
  logic            audio_locked_in = 1'b1;
  logic [N_CH-1:0] nerror_in = 2'b11;
  logic            cfg_done_in = 1'b0;
  logic            clear_fault_in = 1'b0;
  logic            nenable_out;
  logic [N_CH-1:0] nmute_out;
  logic            send_config_out;
  logic            fault_out;
  logic [2:0]      retry_cnt_out;
  logic [2:0]      state_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [N_CH-1:0] exp_q[$];

  amp_seq_multi #(
    .N_CH(N_CH), .EN_WAIT_CYC(EN_W), .CFG_TO_CYC(CFG_T), .FILT_CYC(FILT),
    .RETRY_WAIT_CYC(RW), .MAX_RETRY(MAXR)
  ) dut (
    .clk_in(clk_in), .reset(reset), .audio_locked_in(audio_locked_in),
    .nerror_in(nerror_in), .cfg_done_in(cfg_done_in), .clear_fault_in(clear_fault_in),
    .nenable_out(nenable_out), .nmute_out(nmute_out), .send_config_out(send_config_out),
    .fault_out(fault_out), .retry_cnt_out(retry_cnt_out), .state_out(state_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Push expected mute pattern for current inputs, advance one edge, compare.
  task automatic run_step(input string tag);
    logic [N_CH-1:0] e;
    exp_q.push_back(audio_locked_in ? nerror_in : 2'b00);
    tick();
    e = exp_q.pop_front();
    check_val(tag, nmute_out, e);
  endtask

  task automatic wait_send(input int budget, output int n);
    n = 0;
    while (send_config_out !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check_val("send_seen", send_config_out, 1);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, output int n);
    n = 0;
    while (state_out !== st && n < budget) begin
      tick();
      n++;
    end
    check_val("state_reached", state_out, st);
  endtask

  task automatic do_cfg();
    int n;
    wait_send(30, n);
    tick();
    cfg_done_in = 1'b1;
    run_step("nmute_after_done");
    cfg_done_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state
    repeat (3) tick();
    check_val("rst_state", state_out, S_INIT);
    check_val("rst_nenable", nenable_out, 1);
    check_val("rst_nmute", nmute_out, 0);
    check_val("rst_send", send_config_out, 0);
    check_val("rst_fault", fault_out, 0);
    check_val("rst_retry", retry_cnt_out, 0);
    reset = 1'b1;

    // 1: power-up sequence
    tick();
    check_val("t1_state_enw", state_out, S_ENW);
    check_val("t1_nenable", nenable_out, 0);
    wait_send(30, n);
    check_val("t1_en_wait_len", n, EN_W);
    check_val("t1_state_cfg", state_out, S_CFG);
    tick();
    check_val("t1_send_pulse", send_config_out, 0);
    tick();
    cfg_done_in = 1'b1;
    run_step("t1_nmute_on");
    cfg_done_in = 1'b0;
    check_val("t1_state_run", state_out, S_RUN);

    // 2: short channel-1 fault mutes only that channel
    nerror_in = 2'b01;
    for (int i = 0; i < 5; i++) run_step("t2_nmute_fault");
    nerror_in = 2'b11;
    for (int i = 0; i < 3; i++) run_step("t2_nmute_clear");
    check_val("t2_state", state_out, S_RUN);
    check_val("t2_retry", retry_cnt_out, 0);

    // 6a: loss of audio lock mutes all, no fault
    audio_locked_in = 1'b0;
    for (int i = 0; i < 3; i++) run_step("t6_nmute_unlocked");
    audio_locked_in = 1'b1;
    run_step("t6_nmute_relock");
    check_val("t6_state", state_out, S_RUN);
    check_val("t6_fault", fault_out, 0);

    // 3: persistent channel-0 fault escalates after FILT_CYC cycles
    nerror_in = 2'b10;
    for (int i = 0; i < FILT; i++) run_step("t3_nmute_ch0");
    check_val("t3_still_run", state_out, S_RUN);
    tick();
    check_val("t3_state_fault", state_out, S_FAULT);
    check_val("t3_nmute", nmute_out, 0);
    check_val("t3_nenable", nenable_out, 1);
    check_val("t3_fault", fault_out, 1);
    nerror_in = 2'b11;
    tick();
    check_val("t3_state_rwait", state_out, S_RWAIT);
    check_val("t3_retry", retry_cnt_out, 1);
    wait_state(S_INIT, 40, n);
    check_val("t3_retry_wait_len", n, RW);
    check_val("t3_init_fault", fault_out, 0);
    check_val("t3_init_retry", retry_cnt_out, 1);
    tick();
    check_val("t3_reenable", nenable_out, 0);

    // 4: persistent fault through remaining retries into lockout
    nerror_in = 2'b00;
    for (int r = 2; r <= 4; r++) begin
      do_cfg();
      wait_state(S_FAULT, 40, n);
      tick();
      if (r <= MAXR) begin
        check_val("t4_state_rwait", state_out, S_RWAIT);
        check_val("t4_retry", retry_cnt_out, r);
        if (r == 2) begin
          clear_fault_in = 1'b1;
          tick();
          clear_fault_in = 1'b0;
          check_val("t4_clear_ignored_state", state_out, S_RWAIT);
          check_val("t4_clear_ignored_retry", retry_cnt_out, 2);
        end
        wait_state(S_INIT, 40, n);
      end else begin
        check_val("t4_state_lock", state_out, S_LOCK);
        check_val("t4_lock_retry", retry_cnt_out, MAXR);
      end
    end
    repeat (5) tick();
    check_val("t4_lock_hold", state_out, S_LOCK);
    check_val("t4_lock_fault", fault_out, 1);
    check_val("t4_lock_nenable", nenable_out, 1);
    nerror_in = 2'b11;
    clear_fault_in = 1'b1;
    tick();
    clear_fault_in = 1'b0;
    check_val("t4_clear_state", state_out, S_INIT);
    check_val("t4_clear_retry", retry_cnt_out, 0);
    check_val("t4_clear_fault", fault_out, 0);

    // 5: config timeout, then done on the exact timeout cycle
    wait_send(30, n);
    check_val("t5_send_delay", n, EN_W + 1);
    wait_state(S_FAULT, 40, n);
    check_val("t5_cfg_timeout_len", n, CFG_T);
    tick();
    check_val("t5_retry", retry_cnt_out, 1);
    wait_send(60, n);
    repeat (CFG_T - 1) tick();
    check_val("t5_still_cfg", state_out, S_CFG);
    cfg_done_in = 1'b1;
    run_step("t5_nmute_edge_done");
    cfg_done_in = 1'b0;
    check_val("t5_state_run", state_out, S_RUN);

    // 6b: asynchronous reset while in CFG
    nerror_in = 2'b00;
    wait_state(S_FAULT, 40, n);
    nerror_in = 2'b11;
    wait_send(60, n);
    check_val("t6_retry_before", retry_cnt_out, 2);
    #2 reset = 1'b0;
    #1;
    check_val("t6_async_state", state_out, S_INIT);
    check_val("t6_async_send", send_config_out, 0);
    check_val("t6_async_nenable", nenable_out, 1);
    check_val("t6_async_nmute", nmute_out, 0);
    check_val("t6_async_retry", retry_cnt_out, 0);
    check_val("t6_async_fault", fault_out, 0);
    tick();
    reset = 1'b1;
    tick();
    check_val("t6_restart", state_out, S_ENW);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
